apuf_eval_ctrl: RTL and testbench
=================================

Name: apuf_eval_ctrl

Overview:
- Sequencer for one classic arbiter-PUF instance. It sits between the host/test logic and the PUF.
- Per request it latches a challenge and drives it onto both switch-chain challenge buses. It then fires the trigger NREP times, waiting each time for both paths to arrive and to drain.
- It samples the arbiter bit each time and returns the majority-voted response bit through a start/done handshake.
- Timeouts guard against a stuck delay chain.

Parameters:
- NSTAGE, 128, number of switch stages; width of the challenge buses.
- NREP, 15, evaluations per challenge. Must be odd and ≥1; 1 disables voting.
- SETTLE, 4, cycles the challenge is held with trigger low before each fire. Must be ≥1.
- TIMEOUT, 255, maximum cycles to wait for resp_ready rise or fall. Must be ≥4.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request pulse/level; accepted only when busy=0.
- chal_in, input, NSTAGE, challenge; sampled on the accepted start edge.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle completion pulse.
- resp, output, 1, majority response; held until the next accepted start.
- resp_valid, output, 1, high with done when the evaluation completed without error; held with resp.
- err_timeout, output, 1, sticky timeout flag; cleared on the next accepted start.
- stable, output, 1, all NREP samples agreed (see Optional Feature).
- tig_signal, output, 1, trigger to the PUF; registered.
- c_t, output, NSTAGE, upper-path challenge.
- c_b, output, NSTAGE, lower-path challenge.
- resp_ready, input, 1, from PUF (pathT & pathB); asynchronous.
- resp_bit, input, 1, from PUF arbiter; asynchronous.

Behaviour:
- Reset values: busy=0, done=0, resp=0, resp_valid=0, err_timeout=0, stable=0, tig_signal=0, c_t=c_b=0. Internal counters=0, FSM=IDLE, synchronizers=0.
- Reset mid-operation aborts immediately and returns to the reset values above; no done pulse is issued.
- resp_ready and resp_bit each pass through a 2-flop synchronizer (rdy_s, bit_s) before use.
- c_t=c_b=chal_reg (classic topology). Held constant from LOAD through DONE; never changes while tig_signal=1.
- FSM states and transitions:
  - IDLE: if start, then chal_reg<=chal_in, rep/ones/tmo counters<=0, err_timeout<=0, resp_valid<=0, go to LOAD.
  - LOAD: drive challenge, set settle counter<=0, go to SETTLE.
  - SETTLE: tig_signal=0; after SETTLE cycles go to FIRE.
  - FIRE: tig_signal<=1, tmo<=0, go to WAIT.
  - WAIT: tig_signal=1. If rdy_s=1, go to CAPTURE. Else tmo++; if tmo==TIMEOUT, go to ABORT.
  - CAPTURE: (one extra cycle so bit_s reflects the settled arbiter) ones+=bit_s, rep++, tig_signal<=0, tmo<=0, go to DRAIN.
  - DRAIN: tig_signal=0. If rdy_s=0, go to SETTLE when rep<NREP, else to DONE. Else tmo++; if tmo==TIMEOUT, go to ABORT.
  - DONE: resp<=(ones>NREP/2), resp_valid<=1, stable<=(ones==0 or ones==NREP), done=1 for one cycle, busy<=0, go to IDLE.
  - ABORT: tig_signal<=0, err_timeout<=1, resp_valid<=0, resp unchanged, done=1 for one cycle, busy<=0, go to IDLE.
- Counter widths: rep and ones use $clog2(NREP+1) bits; tmo uses $clog2(TIMEOUT+1) bits. No wrap is possible by construction.
- A start held high in DONE/ABORT is not accepted until IDLE (the next cycle). start while busy is ignored.
- Nominal per-evaluation time: SETTLE+1 (FIRE) +2 (sync) +d +1 (CAPTURE) +2 (sync drain) +d'. Here d and d' are the PUF rise and fall latencies in cycles.

Optional Feature:
- Macro APUF_STABLE_FLAG_EN.
- Defined: stable is computed in DONE as above, cleared on accepted start, forced 0 on ABORT.
- Undefined: stable is tied 0 and no unanimity compare logic is built. The ones counter and the majority vote are unchanged.

Test Plan:
- Basic eval, NREP=15, PUF model: resp_ready rises 3 cycles after tig_signal, resp_bit=1 always -> one done pulse, resp=1, resp_valid=1, stable=1, err_timeout=0, exactly 15 tig_signal rising edges, c_t=c_b=chal_in throughout.
- Majority, PUF returns 1 on 8 of 15 evaluations -> resp=1, stable=0; with 7 of 15 -> resp=0, stable=0.
- Stuck path, resp_ready never rises, TIMEOUT=255 -> done after FIRE+255 WAIT cycles, err_timeout=1, resp_valid=0, tig_signal=0. The next start clears err_timeout.
- Stuck drain, resp_ready stays 1 after trigger drops -> ABORT via DRAIN timeout; same outputs as above.
- start pulsed while busy=1 with a different chal_in -> ignored; c_t/c_b unchanged, single done.
- rst asserted during WAIT of evaluation 5 -> all outputs return to reset values immediately, no done. A fresh start completes normally with 15 evaluations.

Source files
------------

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: repeated triggering, timeout guard and majority vote.
// Optional unanimity flag built only when APUF_STABLE_FLAG_EN is defined.
module apuf_eval_ctrl #(
    parameter int NSTAGE  = 128,
    parameter int NREP    = 15,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [NSTAGE-1:0] chal_in_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              resp_o,
    output logic              resp_valid_o,
    output logic              err_timeout_o,
    output logic              stable_o,
    output logic              tig_signal_o,
    output logic [NSTAGE-1:0] c_t_o,
    output logic [NSTAGE-1:0] c_b_o,
    input  logic              resp_ready_i,
    input  logic              resp_bit_i
);
    // state   | meaning
    // IDLE    | waiting for start
    // LOAD    | challenge registered onto both buses
    // SETTLE  | challenge settling, trigger low
    // FIRE    | raise trigger
    // WAIT    | trigger high, waiting for both paths to arrive
    // CAPTURE | extra cycle so bit_s reflects the settled arbiter, then count it
    // DRAIN   | trigger low, waiting for both paths to fall
    // DONE    | publish majority vote
    // ABORT   | timeout, publish error
    typedef enum logic [3:0] {
        IDLE, LOAD, SETTLE_S, FIRE, WAIT_S, CAPTURE, DRAIN, DONE_S, ABORT
    } state_t;

    localparam int REP_W = $clog2(NREP + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [REP_W-1:0] NREP_C   = REP_W'(NREP);
    localparam logic [REP_W-1:0] HALF_C   = REP_W'(NREP / 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [NSTAGE-1:0] chal_q, chal_d;
    logic [REP_W-1:0]  rep_q, rep_d, ones_q, ones_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic              tig_q, tig_d, busy_q, busy_d, done_q, done_d;
    logic              resp_q, resp_d, valid_q, valid_d, err_q, err_d;
    logic              stable_q, stable_d;
    logic              rdy_meta_q, rdy_s_q, bit_meta_q, bit_s_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
            bit_meta_q <= 1'b0;
            bit_s_q    <= 1'b0;
        end else begin
            rdy_meta_q <= resp_ready_i;
            rdy_s_q    <= rdy_meta_q;
            bit_meta_q <= resp_bit_i;
            bit_s_q    <= bit_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            chal_q   <= '0;
            rep_q    <= '0;
            ones_q   <= '0;
            tmo_q    <= '0;
            set_q    <= '0;
            tig_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resp_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            chal_q   <= chal_d;
            rep_q    <= rep_d;
            ones_q   <= ones_d;
            tmo_q    <= tmo_d;
            set_q    <= set_d;
            tig_q    <= tig_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            resp_q   <= resp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            stable_q <= stable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chal_d   = chal_q;
        rep_d    = rep_q;
        ones_d   = ones_q;
        tmo_d    = tmo_q;
        set_d    = set_q;
        tig_d    = tig_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        resp_d   = resp_q;
        valid_d  = valid_q;
        err_d    = err_q;
        stable_d = stable_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    chal_d   = chal_in_i;
                    rep_d    = '0;
                    ones_d   = '0;
                    tmo_d    = '0;
                    err_d    = 1'b0;
                    valid_d  = 1'b0;
                    stable_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                set_d   = '0;
                state_d = SETTLE_S;
            end
            SETTLE_S: begin
                tig_d = 1'b0;
                if (set_q == SET_LAST) begin
                    set_d   = '0;
                    state_d = FIRE;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            FIRE: begin
                tig_d   = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_S;
            end
            WAIT_S: begin
                if (rdy_s_q) begin
                    state_d = CAPTURE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ABORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CAPTURE: begin
                ones_d  = ones_q + REP_W'(bit_s_q);
                rep_d   = rep_q + 1'b1;
                tig_d   = 1'b0;
                tmo_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!rdy_s_q) begin
                    state_d = (rep_q < NREP_C) ? SETTLE_S : DONE_S;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ABORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE_S: begin
                resp_d   = (ones_q > HALF_C);
                valid_d  = 1'b1;
                stable_d = (ones_q == '0) || (ones_q == NREP_C);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            ABORT: begin
                tig_d    = 1'b0;
                err_d    = 1'b1;
                valid_d  = 1'b0;
                stable_d = 1'b0;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign resp_o        = resp_q;
    assign resp_valid_o  = valid_q;
    assign err_timeout_o = err_q;
    assign tig_signal_o  = tig_q;
    assign c_t_o         = chal_q;
    assign c_b_o         = chal_q;
`ifdef APUF_STABLE_FLAG_EN
    assign stable_o = stable_q;
`else
    // Unanimity register is left unread so synthesis drops the compare.
    assign stable_o = 1'b0;
    logic unused_stable;
    assign unused_stable = stable_q;
`endif
endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for apuf_eval_ctrl with a behavioural arbiter-PUF model.
module tb_apuf_eval_ctrl;
    localparam int NSTAGE = 128;
`ifdef APUF_STABLE_FLAG_EN
    localparam logic STABLE_EN = 1'b1;
`else
    localparam logic STABLE_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [NSTAGE-1:0] chal_in = '0;
    logic busy, done, resp, resp_valid, err_timeout, stable, tig_signal;
    logic [NSTAGE-1:0] c_t, c_b;
    logic resp_ready = 1'b0, resp_bit = 1'b0;

    apuf_eval_ctrl #(.NSTAGE(NSTAGE), .NREP(15), .SETTLE(4), .TIMEOUT(255)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .chal_in_i(chal_in),
        .busy_o(busy), .done_o(done), .resp_o(resp), .resp_valid_o(resp_valid),
        .err_timeout_o(err_timeout), .stable_o(stable), .tig_signal_o(tig_signal),
        .c_t_o(c_t), .c_b_o(c_b), .resp_ready_i(resp_ready), .resp_bit_i(resp_bit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int mode = 0;  // 0 normal, 1 ready stuck low, 2 ready stuck high
    logic [14:0] pat = '1;
    int rise_cnt = 0, tig_hi_cnt = 0, done_cnt = 0, chal_bad = 0;
    logic [NSTAGE-1:0] exp_chal = '0;
    logic tig_prev = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;

    // PUF model and monitors, evaluated on the falling edge
    always @(negedge clk) begin
        if (tig_signal && !tig_prev) begin
            resp_bit = pat[rise_cnt % 15];
            rise_cnt = rise_cnt + 1;
        end
        if (tig_signal) tig_hi_cnt = tig_hi_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (busy && (c_t !== exp_chal || c_b !== exp_chal)) chal_bad = chal_bad + 1;
        tig_prev = tig_signal;
        d3 = d2; d2 = d1; d1 = tig_signal;
        case (mode)
            1:       resp_ready = 1'b0;
            2:       resp_ready = resp_ready | d3;
            default: resp_ready = d3;
        endcase
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [NSTAGE-1:0] ch, input logic [14:0] p, input int m);
        @(negedge clk);
        pat = p; mode = m; rise_cnt = 0; tig_hi_cnt = 0; done_cnt = 0; chal_bad = 0;
        exp_chal = ch; chal_in = ch; start = 1'b1;
        @(negedge clk);
        start = 1'b0; chal_in = ~ch;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check_val({tag, "_done_seen"}, 128'(k < 20000), 128'(1));
        repeat (3) @(negedge clk);
        check_val({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, 128'(busy), 128'(0));
        check_val({tag, "_done"}, 128'(done), 128'(0));
        check_val({tag, "_resp"}, 128'(resp), 128'(0));
        check_val({tag, "_valid"}, 128'(resp_valid), 128'(0));
        check_val({tag, "_err"}, 128'(err_timeout), 128'(0));
        check_val({tag, "_stable"}, 128'(stable), 128'(0));
        check_val({tag, "_tig"}, 128'(tig_signal), 128'(0));
        check_val({tag, "_c_t"}, c_t, 128'(0));
        check_val({tag, "_c_b"}, c_b, 128'(0));
    endtask

    initial begin
        logic [NSTAGE-1:0] ch_a, ch_b;
        int k;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        rst = 1'b0;

        ch_a = {4{32'hDEADBEEF}};
        launch(ch_a, 15'h7FFF, 0);
        wait_done("basic");
        check_val("basic_resp", 128'(resp), 128'(1));
        check_val("basic_valid", 128'(resp_valid), 128'(1));
        check_val("basic_stable", 128'(stable), 128'(STABLE_EN));
        check_val("basic_err", 128'(err_timeout), 128'(0));
        check_val("basic_rises", 128'(rise_cnt), 128'(15));
        check_val("basic_chal", 128'(chal_bad), 128'(0));
        check_val("basic_c_t", c_t, ch_a);
        check_val("basic_tig", 128'(tig_signal), 128'(0));
        check_val("basic_busy", 128'(busy), 128'(0));

        launch(128'h1234, 15'b101010101010101, 0);
        wait_done("maj8");
        check_val("maj8_resp", 128'(resp), 128'(1));
        check_val("maj8_stable", 128'(stable), 128'(0));
        check_val("maj8_rises", 128'(rise_cnt), 128'(15));

        launch(128'h5678, 15'b010101010101010, 0);
        wait_done("maj7");
        check_val("maj7_resp", 128'(resp), 128'(0));
        check_val("maj7_valid", 128'(resp_valid), 128'(1));
        check_val("maj7_stable", 128'(stable), 128'(0));

        launch(128'hA5A5, 15'h7FFF, 1);
        wait_done("stuck");
        check_val("stuck_err", 128'(err_timeout), 128'(1));
        check_val("stuck_valid", 128'(resp_valid), 128'(0));
        check_val("stuck_tig", 128'(tig_signal), 128'(0));
        check_val("stuck_resp_held", 128'(resp), 128'(0));
        check_val("stuck_tig_cycles", 128'(tig_hi_cnt), 128'(256));
        check_val("stuck_rises", 128'(rise_cnt), 128'(1));

        launch(128'h5A5A, 15'h7FFF, 2);
        wait_done("drain");
        check_val("drain_err", 128'(err_timeout), 128'(1));
        check_val("drain_valid", 128'(resp_valid), 128'(0));
        check_val("drain_tig", 128'(tig_signal), 128'(0));
        check_val("drain_rises", 128'(rise_cnt), 128'(1));

        ch_a = 128'hCAFE_0001;
        ch_b = 128'hBEEF_0002;
        launch(ch_a, 15'h7FFF, 0);
        check_val("busy_err_cleared", 128'(err_timeout), 128'(0));
        repeat (30) @(negedge clk);
        chal_in = ch_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy");
        check_val("busy_c_t", c_t, ch_a);
        check_val("busy_c_b", c_b, ch_a);
        check_val("busy_chal", 128'(chal_bad), 128'(0));
        check_val("busy_resp", 128'(resp), 128'(1));
        check_val("busy_rises", 128'(rise_cnt), 128'(15));

        launch(128'hF00D, 15'h7FFF, 0);
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (rise_cnt >= 5) break;
        end
        check_val("rstmid_reach5", 128'(k < 5000), 128'(1));
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_idle_outputs("rstmid");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_val("rstmid_no_done", 128'(done_cnt), 128'(0));

        launch(128'hBEAD, 15'h7FFF, 0);
        wait_done("fresh");
        check_val("fresh_rises", 128'(rise_cnt), 128'(15));
        check_val("fresh_resp", 128'(resp), 128'(1));
        check_val("fresh_valid", 128'(resp_valid), 128'(1));
        check_val("fresh_c_t", c_t, 128'hBEAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
